// File: rtl/addsub_accumulator.sv
// Accumulator that folds a stream of 4-bit operands into a running total.
// Each beat adds or subtracts its operand through one adder/subtractor.
// The batch result is held on a valid/ready output port until it is taken.

// 4-bit two's complement adder/subtractor.
// Subtraction is computed as a + ~b + 1 by inverting b and using mode as the carry-in.
module binary_adder_subtractor (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_mode,
   output logic [3:0] o_sum,
   output logic       o_carry,
   output logic       o_overflow
);

   logic [3:0] w_bEff;
   logic [4:0] w_full;

   // Invert b for subtraction, then do one 5-bit add so the carry-out comes for free.
   // Signed overflow happens when both addends share a sign and the sum's sign differs.
   always_comb begin
      w_bEff     = i_b ^ {4{i_mode}};
      w_full     = {1'b0, i_a} + {1'b0, w_bEff} + {4'b0000, i_mode};
      o_sum      = w_full[3:0];
      o_carry    = w_full[4];
      o_overflow = (i_a[3] == w_bEff[3]) && (w_full[3] != i_a[3]);
   end

endmodule

module addsub_accumulator #(
   parameter int OP_CNT_W = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [3:0]          init_value,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [3:0]          in_operand,
   input  logic                in_mode,
   input  logic                in_last,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [3:0]          out_acc,
   output logic                out_carry,
   output logic                out_overflow,
   output logic [OP_CNT_W-1:0] out_count,
   output logic                busy
);

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } state_t;

   state_t                r_state;
   state_t                w_nextState;
   logic [3:0]            r_acc;
   logic                  r_carry;
   logic                  r_overflow;
   logic [OP_CNT_W-1:0]   r_count;
   logic [3:0]            w_sum;
   logic                  w_carry;
   logic                  w_overflow;
   logic                  w_beatAccept;
   logic                  w_startAccept;

   // The accumulator is always the A operand; each beat supplies B and the mode.
   binary_adder_subtractor u_adder (
      .i_a        (r_acc),
      .i_b        (in_operand),
      .i_mode     (in_mode),
      .o_sum      (w_sum),
      .o_carry    (w_carry),
      .o_overflow (w_overflow)
   );

   // Handshake qualifiers: a start only counts in IDLE, a beat only in ACCUM.
   always_comb begin
      w_startAccept = (r_state == IDLE) && start;
      w_beatAccept  = (r_state == ACCUM) && in_valid;
   end

   // State register; reset abandons any batch in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic. A DONE result leaves only on out_ready, and a start seen
   // in that same cycle is dropped because start is only sampled from IDLE.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_nextState = ACCUM;
            end
         end
         ACCUM: begin
            if (in_valid && in_last) begin
               w_nextState = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Result registers: seeded on an accepted start, updated on each accepted beat,
   // otherwise held so IDLE and DONE both show the last batch values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_acc      <= 4'h0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_count    <= '0;
      end else if (w_startAccept) begin
         r_acc      <= init_value;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
         r_count    <= '0;
      end else if (w_beatAccept) begin
         r_acc      <= w_sum;
         r_carry    <= w_carry;
         r_overflow <= r_overflow | w_overflow;
         if (r_count != {OP_CNT_W{1'b1}}) begin
            r_count <= r_count + OP_CNT_W'(1);
         end
      end
   end

   // Port decode: handshake strobes come straight from the state, data from the registers.
   always_comb begin
      in_ready     = (r_state == ACCUM);
      out_valid    = (r_state == DONE);
      busy         = (r_state != IDLE);
      out_acc      = r_acc;
      out_carry    = r_carry;
      out_overflow = r_overflow;
      out_count    = r_count;
   end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Bench for addsub_accumulator: directed batches with hand-computed results.
// Expected batch results are queued when the last beat is issued; a monitor
// pops and compares them whenever the DUT hands a result over.
module tb_addsub_accumulator;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] init_value;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] in_operand;
   logic       in_mode;
   logic       in_last;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_acc;
   logic       out_carry;
   logic       out_overflow;
   logic [3:0] out_count;
   logic       busy;

   typedef struct packed {
      logic [3:0] acc;
      logic       carry;
      logic       ovf;
      logic [3:0] count;
   } expect_t;

   expect_t expQueue[$];
   int      checkCount = 0;
   int      errorCount = 0;

   addsub_accumulator #(.OP_CNT_W(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .init_value   (init_value),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_operand   (in_operand),
      .in_mode      (in_mode),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_acc      (out_acc),
      .out_carry    (out_carry),
      .out_overflow (out_overflow),
      .out_count    (out_count),
      .busy         (busy)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic checkIdleZero(input string tag);
      checkOutput({tag, "_inReady"}, in_ready, 0);
      checkOutput({tag, "_outValid"}, out_valid, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_acc"}, out_acc, 0);
      checkOutput({tag, "_carry"}, out_carry, 0);
      checkOutput({tag, "_overflow"}, out_overflow, 0);
      checkOutput({tag, "_count"}, out_count, 0);
   endtask

   task automatic startBatch(input logic [3:0] initVal);
      start      = 1'b1;
      init_value = initVal;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("startInReady", in_ready, 1);
      checkOutput("startBusy", busy, 1);
      checkOutput("startAcc", out_acc, {28'd0, initVal});
   endtask

   task automatic applyStimulus(input logic [3:0] operand, input logic mode, input logic last);
      checkOutput("beatInReady", in_ready, 1);
      in_valid   = 1'b1;
      in_operand = operand;
      in_mode    = mode;
      in_last    = last;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Monitor: every result handshake must match the oldest queued expectation.
   initial begin
      expect_t e;
      forever begin
         @(negedge clk);
         if (out_valid && out_ready) begin
            if (expQueue.size() == 0) begin
               checkCount++;
               errorCount++;
               $display("[TB] FAIL unexpectedResult: got out_valid=1 acc=%0h, expected no result at %0t", out_acc, $time);
            end else begin
               e = expQueue.pop_front();
               checkOutput("resultAcc", out_acc, e.acc);
               checkOutput("resultCarry", out_carry, e.carry);
               checkOutput("resultOverflow", out_overflow, e.ovf);
               checkOutput("resultCount", out_count, e.count);
            end
         end
      end
   end

   // Watchdog so the run can never hang.
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset      = 1'b1;
      start      = 1'b0;
      init_value = 4'h0;
      in_valid   = 1'b0;
      in_operand = 4'h0;
      in_mode    = 1'b0;
      in_last    = 1'b0;
      out_ready  = 1'b1;

      #3;
      checkIdleZero("inReset");
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      checkIdleZero("afterReset");

      $display("[TB] add with overflow");
      startBatch(4'd3);
      applyStimulus(4'd4, 1'b0, 1'b0);
      checkOutput("t1MidValid", out_valid, 0);
      checkOutput("t1MidAcc", out_acc, 4'h7);
      expQueue.push_back('{acc: 4'hC, carry: 1'b0, ovf: 1'b1, count: 4'd2});
      applyStimulus(4'd5, 1'b0, 1'b1);
      checkOutput("t1ValidRise", out_valid, 1);
      checkOutput("t1DoneInReady", in_ready, 0);
      @(posedge clk);
      #1;
      checkOutput("t1IdleValid", out_valid, 0);
      checkOutput("t1IdleBusy", busy, 0);
      checkOutput("t1IdleAccHeld", out_acc, 4'hC);

      $display("[TB] subtract without borrow");
      startBatch(4'd5);
      expQueue.push_back('{acc: 4'h2, carry: 1'b1, ovf: 1'b0, count: 4'd1});
      applyStimulus(4'd3, 1'b1, 1'b1);
      @(posedge clk);
      #1;

      $display("[TB] borrow wrap");
      startBatch(4'd0);
      expQueue.push_back('{acc: 4'hF, carry: 1'b0, ovf: 1'b0, count: 4'd1});
      applyStimulus(4'd1, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("t3IdleAccHeld", out_acc, 4'hF);
      checkOutput("t3IdleCountHeld", out_count, 1);
      startBatch(4'd7);
      checkOutput("t3ClearOverflow", out_overflow, 0);
      checkOutput("t3ClearCount", out_count, 0);
      checkOutput("t3ClearCarry", out_carry, 0);

      $display("[TB] backpressure");
      out_ready = 1'b0;
      expQueue.push_back('{acc: 4'h8, carry: 1'b0, ovf: 1'b1, count: 4'd1});
      applyStimulus(4'd1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         start      = 1'b1;
         init_value = 4'h3;
         in_valid   = 1'b1;
         in_operand = 4'h3;
         @(posedge clk);
         #1;
         checkOutput("t4HoldValid", out_valid, 1);
         checkOutput("t4HoldInReady", in_ready, 0);
         checkOutput("t4HoldAcc", out_acc, 4'h8);
         checkOutput("t4HoldCarry", out_carry, 0);
         checkOutput("t4HoldOverflow", out_overflow, 1);
         checkOutput("t4HoldCount", out_count, 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      checkOutput("t4ReleaseValid", out_valid, 0);
      checkOutput("t4StartDropped", in_ready, 0);
      checkOutput("t4ReleaseBusy", busy, 0);
      checkOutput("t4ReleaseAcc", out_acc, 4'h8);

      $display("[TB] reset mid-batch");
      @(posedge clk);
      #1;
      startBatch(4'd2);
      applyStimulus(4'd1, 1'b0, 1'b0);
      applyStimulus(4'd1, 1'b0, 1'b0);
      checkOutput("t5PreResetAcc", out_acc, 4'h4);
      #2;
      reset = 1'b1;
      #1;
      checkIdleZero("midReset");
      #2;
      reset = 1'b0;
      @(posedge clk);
      #1;
      startBatch(4'd1);
      expQueue.push_back('{acc: 4'h2, carry: 1'b0, ovf: 1'b0, count: 4'd1});
      applyStimulus(4'd1, 1'b0, 1'b1);
      @(posedge clk);
      #1;

      $display("[TB] count saturation");
      startBatch(4'd0);
      expQueue.push_back('{acc: 4'h1, carry: 1'b0, ovf: 1'b1, count: 4'd15});
      for (int i = 0; i < 16; i++) begin
         applyStimulus(4'd1, 1'b0, 1'b0);
      end
      applyStimulus(4'd1, 1'b0, 1'b1);
      checkOutput("t6DoneCount", out_count, 15);
      @(posedge clk);
      #1;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("queueDrained", expQueue.size(), 0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
